// File: rtl/jtcop_bus_pkg.sv
// Shared types for the 68000 bus responder: FSM states, source-select codes,
// open-bus value and the chip-select priority encoder.
package jtcop_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OKWAIT  = 2'd1,
    ST_FIXWAIT = 2'd2,
    ST_ACK     = 2'd3
  } bus_state_t;

  typedef enum logic [3:0] {
    SRC_ROM  = 4'd0,
    SRC_RAM  = 4'd1,
    SRC_OBJ  = 4'd2,
    SRC_PAL0 = 4'd3,
    SRC_PAL1 = 4'd4,
    SRC_HUC  = 4'd5,
    SRC_DISP = 4'd6,
    SRC_CAB  = 4'd7,
    SRC_SYS  = 4'd8,
    SRC_DIP  = 4'd9,
    SRC_NONE = 4'd15
  } src_t;

  localparam logic [15:0] OPEN_BUS = 16'hffff;

  // Fixed priority, highest first, when the decoder raises several selects
  function automatic src_t src_encode(
    input logic       rom_cs,
    input logic       ram_cs,
    input logic       obj_cs,
    input logic [1:0] pal_cs,
    input logic       huc_cs,
    input logic       disp_cs,
    input logic [2:0] read_cs
  );
    src_t src;
    if      (rom_cs)     src = SRC_ROM;
    else if (ram_cs)     src = SRC_RAM;
    else if (obj_cs)     src = SRC_OBJ;
    else if (pal_cs[0])  src = SRC_PAL0;
    else if (pal_cs[1])  src = SRC_PAL1;
    else if (huc_cs)     src = SRC_HUC;
    else if (disp_cs)    src = SRC_DISP;
    else if (read_cs[0]) src = SRC_CAB;
    else if (read_cs[1]) src = SRC_SYS;
    else if (read_cs[2]) src = SRC_DIP;
    else                 src = SRC_NONE;
    return src;
  endfunction

endpackage

// File: rtl/jtcop_okfilter.sv
// Stale-ok filter for one SDRAM source: an ok seen within OK_GUARD clocks of
// the cycle start belongs to the previous access and is ignored.
module jtcop_okfilter #(
  parameter int OK_GUARD = 2,
  parameter int TW       = 7
) (
  input  logic rst,
  input  logic clk,
  input  logic load,
  input  logic ok,
  output logic ok_q
);

  localparam logic [TW-1:0] GUARD_ONE  = TW'(1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'(OK_GUARD);

  logic [TW-1:0] guard_r;

  // Guard counter: reloaded at cycle start, counts down and sticks at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_r <= {TW{1'b0}};
    end else if (load) begin
      guard_r <= GUARD_LOAD;
    end else if (guard_r != {TW{1'b0}}) begin
      guard_r <= guard_r - GUARD_ONE;
    end else begin
      guard_r <= guard_r;
    end
  end

  assign ok_q = ok && (guard_r == {TW{1'b0}});

endmodule

// File: rtl/jtcop_bus_resp.sv
// 68000 bus-cycle responder: DTACKn generation, read-data latch and timeout.
// Build option JTCOP_BUSERR_EN turns unmapped-cycle timeouts into BERRn.
module jtcop_bus_resp
  import jtcop_bus_pkg::*;
#(
  parameter int FIX_WAIT = 2,
  parameter int OK_GUARD = 2,
  parameter int TIMEOUT  = 64,
  parameter int TW       = 7
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        ASn,
  input  logic        RnW,
  input  logic        rom_cs,
  input  logic        ram_cs,
  input  logic        obj_cs,
  input  logic [1:0]  pal_cs,
  input  logic        huc_cs,
  input  logic        disp_cs,
  input  logic [2:0]  read_cs,
  input  logic [15:0] rom_data,
  input  logic        rom_ok,
  input  logic [15:0] ram_data,
  input  logic        ram_ok,
  input  logic [15:0] obj_data,
  input  logic [15:0] pal_data,
  input  logic [7:0]  huc_data,
  input  logic [15:0] disp_data,
  input  logic [15:0] cab_data,
  input  logic [15:0] sys_data,
  input  logic [15:0] dip_data,
  output logic        DTACKn,
  output logic        BERRn,
  output logic [15:0] cpu_din,
  output logic        busy
);

  localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);
  localparam logic [TW-1:0] CNT_FIX  = TW'(FIX_WAIT);
  localparam logic [TW-1:0] CNT_TOUT = TW'(TIMEOUT);

  bus_state_t    state_r, state_s;
  src_t          src_r, src_s, sel_s;
  logic [TW-1:0] cnt_r, cnt_s;
  logic          asn_l_r;
  logic          dtack_n_r, dtack_n_s;
  logic          berr_n_r, berr_n_s;
  logic [15:0]   din_r, din_s;
  logic          busy_r;
  logic          start_s, done_s, ok_s;
  logic          rom_okq_s, ram_okq_s;
  logic [15:0]   rd_data_s;

  assign start_s = !ASn && asn_l_r && (state_r == ST_IDLE);
  assign sel_s   = src_encode(rom_cs, ram_cs, obj_cs, pal_cs, huc_cs, disp_cs, read_cs);

  jtcop_okfilter #(.OK_GUARD(OK_GUARD), .TW(TW)) u_rom_ok (
    .rst (rst),
    .clk (clk),
    .load(start_s),
    .ok  (rom_ok),
    .ok_q(rom_okq_s)
  );

  jtcop_okfilter #(.OK_GUARD(OK_GUARD), .TW(TW)) u_ram_ok (
    .rst (rst),
    .clk (clk),
    .load(start_s),
    .ok  (ram_ok),
    .ok_q(ram_okq_s)
  );

  // Read-data mux driven by the select captured at cycle start
  always_comb begin
    rd_data_s = OPEN_BUS;
    case (src_r)
      SRC_ROM:  rd_data_s = rom_data;
      SRC_RAM:  rd_data_s = ram_data;
      SRC_OBJ:  rd_data_s = obj_data;
      SRC_PAL0: rd_data_s = pal_data;
      SRC_PAL1: rd_data_s = pal_data;
      SRC_HUC:  rd_data_s = {8'hff, huc_data};
      SRC_DISP: rd_data_s = disp_data;
      SRC_CAB:  rd_data_s = cab_data;
      SRC_SYS:  rd_data_s = sys_data;
      SRC_DIP:  rd_data_s = dip_data;
      default:  rd_data_s = OPEN_BUS;
    endcase
  end

  assign ok_s = (src_r == SRC_ROM) ? rom_okq_s : ram_okq_s;

  // Bus-cycle FSM next state; a rising ASn before completion aborts silently
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    src_s     = src_r;
    dtack_n_s = dtack_n_r;
    berr_n_s  = berr_n_r;
    din_s     = din_r;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        dtack_n_s = 1'b1;
        berr_n_s  = 1'b1;
        if (start_s) begin
          src_s = sel_s;
          if (sel_s == SRC_ROM || sel_s == SRC_RAM) begin
            state_s = ST_OKWAIT;
            cnt_s   = CNT_ZERO;
          end else if (sel_s == SRC_NONE) begin
            state_s = ST_FIXWAIT;
            cnt_s   = CNT_TOUT;
          end else begin
            state_s = ST_FIXWAIT;
            cnt_s   = CNT_FIX;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OKWAIT: begin
        if (ASn) begin
          state_s = ST_IDLE;
        end else if (ok_s) begin
          done_s = 1'b1;
        end else begin
          state_s = ST_OKWAIT;
        end
      end
      ST_FIXWAIT: begin
        if (ASn) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          done_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_ACK: begin
        if (ASn) begin
          state_s   = ST_IDLE;
          dtack_n_s = 1'b1;
          berr_n_s  = 1'b1;
        end else begin
          state_s = ST_ACK;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        dtack_n_s = 1'b1;
        berr_n_s  = 1'b1;
      end
    endcase

    if (done_s) begin
      state_s = ST_ACK;
      if (RnW) begin
        din_s = rd_data_s;
      end else begin
        din_s = din_r;
      end
`ifdef JTCOP_BUSERR_EN
      if (src_r == SRC_NONE) begin
        berr_n_s = 1'b0;
      end else begin
        dtack_n_s = 1'b0;
      end
`else
      dtack_n_s = 1'b0;
`endif
    end else begin
      din_s = din_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      src_r     <= SRC_NONE;
      cnt_r     <= CNT_ZERO;
      asn_l_r   <= 1'b0;
      dtack_n_r <= 1'b1;
      berr_n_r  <= 1'b1;
      din_r     <= 16'h0000;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      src_r     <= src_s;
      cnt_r     <= cnt_s;
      asn_l_r   <= ASn;
      dtack_n_r <= dtack_n_s;
      berr_n_r  <= berr_n_s;
      din_r     <= din_s;
      busy_r    <= (state_s == ST_OKWAIT) || (state_s == ST_FIXWAIT);
    end
  end

  assign DTACKn  = dtack_n_r;
  assign BERRn   = berr_n_r;
  assign cpu_din = din_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_jtcop_bus_resp.sv
// Directed bench for jtcop_bus_resp: SDRAM/BRAM latency, stale ok, priority,
// unmapped timeout (both JTCOP_BUSERR_EN builds), abort and async reset.
module tb_jtcop_bus_resp;

  logic        rst, clk;
  logic        ASn, RnW;
  logic        rom_cs, ram_cs, obj_cs, huc_cs, disp_cs;
  logic [1:0]  pal_cs;
  logic [2:0]  read_cs;
  logic [15:0] rom_data, ram_data, obj_data, pal_data, disp_data;
  logic [15:0] cab_data, sys_data, dip_data;
  logic [7:0]  huc_data;
  logic        rom_ok, ram_ok;
  logic        DTACKn, BERRn, busy;
  logic [15:0] cpu_din;

  int n_chk  = 0;
  int n_fail = 0;

  jtcop_bus_resp dut (
    .rst(rst), .clk(clk), .ASn(ASn), .RnW(RnW),
    .rom_cs(rom_cs), .ram_cs(ram_cs), .obj_cs(obj_cs), .pal_cs(pal_cs),
    .huc_cs(huc_cs), .disp_cs(disp_cs), .read_cs(read_cs),
    .rom_data(rom_data), .rom_ok(rom_ok), .ram_data(ram_data), .ram_ok(ram_ok),
    .obj_data(obj_data), .pal_data(pal_data), .huc_data(huc_data),
    .disp_data(disp_data), .cab_data(cab_data), .sys_data(sys_data),
    .dip_data(dip_data), .DTACKn(DTACKn), .BERRn(BERRn), .cpu_din(cpu_din),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ASn = 1'b1; RnW = 1'b1;
    rom_cs = 1'b0; ram_cs = 1'b0; obj_cs = 1'b0; pal_cs = 2'b00;
    huc_cs = 1'b0; disp_cs = 1'b0; read_cs = 3'b000;
    rom_ok = 1'b0; ram_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    rom_data = 16'h4e71; ram_data = 16'h1234; obj_data = 16'habcd;
    pal_data = 16'h0f0f; huc_data = 8'h5a; disp_data = 16'h7777;
    cab_data = 16'hc0c0; sys_data = 16'h5353; dip_data = 16'hd1d1;
    step(); step();
    chk("rst_dtack", {15'd0, DTACKn}, 16'h0001);
    chk("rst_berr",  {15'd0, BERRn},  16'h0001);
    chk("rst_din",   cpu_din,         16'h0000);
    chk("rst_busy",  {15'd0, busy},   16'h0000);
    rst = 1'b0;
    step();

    // 1: ROM read, ok 5 clk after start -> DTACKn at clk 6
    rom_cs = 1'b1; ASn = 1'b0;
    step();
    chk("rom_busy0", {15'd0, busy}, 16'h0001);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("rom_wait", {15'd0, DTACKn}, 16'h0001);
    end
    rom_ok = 1'b1;
    step();
    chk("rom_dtack6", {15'd0, DTACKn}, 16'h0000);
    chk("rom_din",    cpu_din,         16'h4e71);
    chk("rom_busy6",  {15'd0, busy},   16'h0000);
    rom_ok = 1'b0; rom_data = 16'h0000;
    step();
    chk("rom_hold_dtack", {15'd0, DTACKn}, 16'h0000);
    chk("rom_hold_din",   cpu_din,         16'h4e71);
    idle_bus();
    step();
    chk("rom_release", {15'd0, DTACKn}, 16'h0001);
    chk("rom_keep_din", cpu_din,        16'h4e71);
    step();

    // 2: stale ram_ok filtered; fresh ok at clk 4 -> DTACKn at clk 5
    ram_cs = 1'b1; ram_ok = 1'b1; ASn = 1'b0;
    step();
    step();
    chk("stale_ok1", {15'd0, DTACKn}, 16'h0001);
    ram_ok = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("stale_wait", {15'd0, DTACKn}, 16'h0001);
    end
    ram_ok = 1'b1;
    step();
    chk("ram_dtack5", {15'd0, DTACKn}, 16'h0000);
    chk("ram_din",    cpu_din,         16'h1234);
    idle_bus();
    step(); step();

    // RAM write with ok held high: first honoured at clk 3, no data latch
    ram_cs = 1'b1; ram_ok = 1'b1; RnW = 1'b0; ram_data = 16'h9999; ASn = 1'b0;
    step(); step(); step();
    chk("wr_guard2", {15'd0, DTACKn}, 16'h0001);
    step();
    chk("wr_dtack3", {15'd0, DTACKn}, 16'h0000);
    chk("wr_nolatch", cpu_din,        16'h1234);
    idle_bus();
    step(); step();

    // 3: palette read, FIX_WAIT=2 -> DTACKn 3 clk after start
    pal_cs = 2'b10; ASn = 1'b0;
    step(); step(); step();
    chk("pal_wait2", {15'd0, DTACKn}, 16'h0001);
    step();
    chk("pal_dtack3", {15'd0, DTACKn}, 16'h0000);
    chk("pal_din",    cpu_din,         16'h0f0f);
    idle_bus();
    step(); step();

    // Priority: huc beats disp and read selects, high byte open
    huc_cs = 1'b1; disp_cs = 1'b1; read_cs = 3'b111; ASn = 1'b0;
    step(); step(); step(); step();
    chk("prio_huc", cpu_din, 16'hff5a);
    idle_bus();
    step(); step();

    // Priority: cabinet beats system and DIP
    read_cs = 3'b111; ASn = 1'b0;
    step(); step(); step(); step();
    chk("prio_cab", cpu_din, 16'hc0c0);
    idle_bus();
    step(); step();

    // 4: unmapped read times out at clk 65
    ASn = 1'b0;
    step();
    for (int i = 1; i <= 64; i++) step();
    chk("unm_wait64_dtack", {15'd0, DTACKn}, 16'h0001);
    chk("unm_wait64_berr",  {15'd0, BERRn},  16'h0001);
    step();
`ifdef JTCOP_BUSERR_EN
    chk("unm_berr65",  {15'd0, BERRn},  16'h0000);
    chk("unm_dtack65", {15'd0, DTACKn}, 16'h0001);
`else
    chk("unm_dtack65", {15'd0, DTACKn}, 16'h0000);
    chk("unm_berr65",  {15'd0, BERRn},  16'h0001);
`endif
    chk("unm_din", cpu_din, 16'hffff);
    idle_bus();
    step();
    chk("unm_rel_dtack", {15'd0, DTACKn}, 16'h0001);
    chk("unm_rel_berr",  {15'd0, BERRn},  16'h0001);
    step();

    // 5: abort an obj read at clk 1, then restart next clk
    obj_cs = 1'b1; ASn = 1'b0;
    step();
    chk("abort_busy0", {15'd0, busy}, 16'h0001);
    ASn = 1'b1;
    step();
    chk("abort_busy1",  {15'd0, busy},   16'h0000);
    chk("abort_dtack1", {15'd0, DTACKn}, 16'h0001);
    chk("abort_din",    cpu_din,         16'hffff);
    ASn = 1'b0;
    step();
    chk("restart_busy", {15'd0, busy}, 16'h0001);
    step(); step();
    chk("restart_wait", {15'd0, DTACKn}, 16'h0001);
    step();
    chk("restart_dtack", {15'd0, DTACKn}, 16'h0000);
    chk("restart_din",   cpu_din,         16'habcd);
    idle_bus();
    step(); step();

    // 6: async reset in OKWAIT, then a late ok without a new ASn fall
    rom_cs = 1'b1; rom_data = 16'h2468; ASn = 1'b0;
    step(); step();
    chk("pre_rst_busy", {15'd0, busy}, 16'h0001);
    #1 rst = 1'b1;
    #1;
    chk("arst_dtack", {15'd0, DTACKn}, 16'h0001);
    chk("arst_berr",  {15'd0, BERRn},  16'h0001);
    chk("arst_din",   cpu_din,         16'h0000);
    chk("arst_busy",  {15'd0, busy},   16'h0000);
    #1 rst = 1'b0;
    rom_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_dtack", {15'd0, DTACKn}, 16'h0001);
      chk("post_rst_busy",  {15'd0, busy},   16'h0000);
    end
    idle_bus();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
